ram_1r1w: RTL and testbench

Byte-enabled, one-read-port/one-write-port synchronous RAM wrapper. It is the storage behind the AHB3-Lite single-port SRAM slave. That slave issues writes one cycle late because of the pipelined AHB address/data phases, so the RAM must sustain a read and a write in the same cycle. The `TECHNOLOGY` parameter selects the macro implementation; `"GENERIC"` infers a register/RAM array.

---
 rtl/ram_1r1w_pkg.sv | 15 +
 rtl/ram_1r1w_generic.sv | 62 ++++++
 rtl/ram_1r1w.sv | 105 ++++++++++
 tb/tb_ram_1r1w.sv | 131 +++++++++++++
 4 files changed

// File: rtl/ram_1r1w_pkg.sv
// ram_1r1w_pkg
//   Shared definitions for the ram_1r1w storage wrapper.
//   - TECH_GENERIC : TECHNOLOGY value that selects the inferred array
//   - BE_BITS()    : byte-lane count for a given data width
//   The configuration macro RAM_1R1W_RDW_BYPASS_EN is consumed by ram_1r1w.sv.
package ram_1r1w_pkg;

    localparam TECH_GENERIC = "GENERIC";

    // One enable per 8-bit lane; the top lane may be narrower than 8 bits.
    function automatic int BE_BITS(input int dbits);
        return (dbits + 7) / 8;
    endfunction

endpackage

// File: rtl/ram_1r1w_generic.sv
// ram_1r1w_generic
//   Inferred 1R1W storage: mem_array plus the registered read port.
//   Ports:
//     clk    - rising-edge clock
//     rstn   - synchronous active-low reset (clears dout, never the array)
//     waddr  - write word address
//     we     - write enable
//     be     - byte-lane enables for the write
//     din    - write data
//     raddr  - read word address, sampled every edge
//     dout   - registered read data (old word on same-address collision)
module ram_1r1w_generic
    import ram_1r1w_pkg::*;
#(
    parameter int ABITS = 10,
    parameter int DBITS = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [ABITS-1:0]           waddr,
    input  logic                       we,
    input  logic [BE_BITS(DBITS)-1:0]  be,
    input  logic [DBITS-1:0]           din,
    input  logic [ABITS-1:0]           raddr,
    output logic [DBITS-1:0]           dout
);

    logic [DBITS-1:0] mem_array [0:2**ABITS-1];

    logic [DBITS-1:0] wmask;
    logic [DBITS-1:0] wdata_d;
    logic [DBITS-1:0] dout_d;
    logic [DBITS-1:0] dout_q;

    // Expand lane enables to a per-bit mask; the top lane truncates naturally.
    for (genvar b = 0; b < DBITS; b++) begin : g_wmask
        assign wmask[b] = be[b/8];
    end

    always_comb begin
        wdata_d = (mem_array[waddr] & ~wmask) | (din & wmask);
        dout_d  = mem_array[raddr];
    end

    // The array has no reset so a preload survives rstn; writes are dropped in reset.
    always_ff @(posedge clk) begin
        if (rstn && we) begin
            mem_array[waddr] <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/ram_1r1w.sv
// ram_1r1w
//   Byte-enabled one-read/one-write synchronous RAM wrapper.
//   Parameters: ABITS (address width), DBITS (data width),
//               TECHNOLOGY (macro select; anything unrecognised maps to generic).
//   Ports:
//     clk    - rising-edge clock
//     rstn   - synchronous active-low reset
//     waddr  - write word address
//     we     - write enable
//     be     - byte-lane enables, bit i covers din[8i+7:8i]
//     din    - write data
//     raddr  - read word address, sampled every edge
//     dout   - registered read data, 1-cycle latency
//   Macro RAM_1R1W_RDW_BYPASS_EN: when defined, a same-address read during
//   write returns the new data on every enabled lane.
module ram_1r1w
    import ram_1r1w_pkg::*;
#(
    parameter int ABITS      = 10,
    parameter int DBITS      = 32,
    parameter     TECHNOLOGY = "GENERIC"
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [ABITS-1:0]           waddr,
    input  logic                       we,
    input  logic [BE_BITS(DBITS)-1:0]  be,
    input  logic [DBITS-1:0]           din,
    input  logic [ABITS-1:0]           raddr,
    output logic [DBITS-1:0]           dout
);

    localparam bit IS_GENERIC = (TECHNOLOGY == TECH_GENERIC);

    logic [DBITS-1:0] ram_dout;

    // No vendor macros are wired up yet, so both branches use the inferred
    // array. Both blocks carry the same name to keep the preload path stable.
    if (IS_GENERIC) begin : genblk1
        ram_1r1w_generic #(
            .ABITS (ABITS),
            .DBITS (DBITS)
        ) ram_inst (
            .clk   (clk),
            .rstn  (rstn),
            .waddr (waddr),
            .we    (we),
            .be    (be),
            .din   (din),
            .raddr (raddr),
            .dout  (ram_dout)
        );
    end else begin : genblk1
        ram_1r1w_generic #(
            .ABITS (ABITS),
            .DBITS (DBITS)
        ) ram_inst (
            .clk   (clk),
            .rstn  (rstn),
            .waddr (waddr),
            .we    (we),
            .be    (be),
            .din   (din),
            .raddr (raddr),
            .dout  (ram_dout)
        );
    end

`ifdef RAM_1R1W_RDW_BYPASS_EN
    logic [DBITS-1:0] lane_mask;
    logic [DBITS-1:0] byp_mask_d;
    logic [DBITS-1:0] byp_mask_q;
    logic [DBITS-1:0] byp_data_d;
    logic [DBITS-1:0] byp_data_q;

    for (genvar b = 0; b < DBITS; b++) begin : g_lane_mask
        assign lane_mask[b] = be[b/8];
    end

    // Compare is registered alongside the array read, so dout is a mux of
    // flops only and has no combinational path from the inputs.
    always_comb begin
        byp_mask_d = '0;
        byp_data_d = din;
        if (we && (waddr == raddr)) begin
            byp_mask_d = lane_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            byp_mask_q <= '0;
            byp_data_q <= '0;
        end else begin
            byp_mask_q <= byp_mask_d;
            byp_data_q <= byp_data_d;
        end
    end

    assign dout = (byp_data_q & byp_mask_q) | (ram_dout & ~byp_mask_q);
`else
    assign dout = ram_dout;
`endif

endmodule

// File: tb/tb_ram_1r1w.sv
module tb_ram_1r1w;

    localparam int AB = 4;
    localparam int DB = 32;
`ifdef RAM_1R1W_RDW_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rstn  = 1'b0;
    logic          we    = 1'b0;
    logic [AB-1:0] waddr = '0;
    logic [AB-1:0] raddr = '0;
    logic [3:0]    be    = '0;
    logic [DB-1:0] din   = '0;
    logic [DB-1:0] dout;

    always #5 clk = ~clk;

    ram_1r1w #(
        .ABITS      (AB),
        .DBITS      (DB),
        .TECHNOLOGY ("GENERIC")
    ) ram_inst (
        .clk   (clk),
        .rstn  (rstn),
        .waddr (waddr),
        .we    (we),
        .be    (be),
        .din   (din),
        .raddr (raddr),
        .dout  (dout)
    );

    typedef struct {
        string         tag;
        logic [DB-1:0] exp;
    } sb_t;

    sb_t           sb_q[$];
    logic [DB-1:0] mm [16];
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic chk(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h exp %08h", tag, got, exp);
        end
    endtask

    // Drive one cycle, push the expected dout, then pop and compare after the edge.
    task automatic step(input logic r, input logic w, input logic [AB-1:0] wa,
                        input logic [3:0] b, input logic [DB-1:0] d,
                        input logic [AB-1:0] ra, input string tag);
        sb_t           s;
        logic [DB-1:0] e;
        rstn  = r;
        we    = w;
        waddr = wa;
        be    = b;
        din   = d;
        raddr = ra;
        if (!r) begin
            e = '0;
        end else begin
            e = mm[ra];
            if (BYP && w && (wa == ra)) begin
                for (int l = 0; l < 4; l++) if (b[l]) e[8*l +: 8] = d[8*l +: 8];
            end
        end
        if (r && w) begin
            for (int l = 0; l < 4; l++) if (b[l]) mm[wa][8*l +: 8] = d[8*l +: 8];
        end
        s.tag = tag;
        s.exp = e;
        sb_q.push_back(s);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_empty"}, dout, 'x);
        end else begin
            s = sb_q.pop_front();
            chk(s.tag, dout, s.exp);
        end
    endtask

    initial begin
        // Preload the array directly through the hierarchy during reset.
        for (int i = 0; i < 16; i++) begin
            mm[i] = {8{i[3:0], i[3:0]}} & 32'hFFFF_FFFF;
            mm[i] = {4{i[3:0], i[3:0]}};
        end
        mm[0] = 32'hA5A5_A5A5;
        mm[5] = 32'h1111_1111;
        mm[2] = 32'h2222_2222;
        for (int i = 0; i < 16; i++) ram_inst.genblk1.ram_inst.mem_array[i] = mm[i];

        step(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 4'd0, "rst_c0");
        step(1'b0, 1'b1, 4'd0, 4'hF, 32'hFFFF_FFFF, 4'd0, "rst_c1_wr_drop");
        step(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 4'd0, "preload_a0");
        step(1'b1, 1'b1, 4'd3, 4'hF, 32'hDEAD_BEEF, 4'd0, "wr3_rd0");
        step(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 4'd3, "rd3_full");
        step(1'b1, 1'b1, 4'd3, 4'b0010, 32'h0000_AA00, 4'd3, "wr3_part_rdw");
        step(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 4'd3, "rd3_part");
        step(1'b1, 1'b0, 4'd3, 4'hF, 32'h0, 4'd3, "we0_be_f");
        step(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 4'd3, "rd3_after_we0");
        step(1'b1, 1'b1, 4'd5, 4'hF, 32'h1234_5678, 4'd5, "rdw5");
        step(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 4'd5, "rd5_after");
        step(1'b1, 1'b1, 4'd7, 4'hF, 32'hCAFE_F00D, 4'd2, "wr7_rd2");
        step(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 4'd7, "rd7");
        step(1'b0, 1'b1, 4'd3, 4'hF, 32'h0, 4'd3, "rst_mid_wr3");
        step(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 4'd3, "rd3_post_rst");
        step(1'b1, 1'b1, 4'd9, 4'b1001, 32'h7700_0066, 4'd9, "rdw9_lanes03");
        step(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 4'd9, "rd9");

        // Random traffic over a few addresses so collisions are frequent.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(31) != 0), 1'($urandom_range(1)),
                 4'($urandom_range(3)), 4'($urandom_range(15)), $urandom(),
                 4'($urandom_range(3)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
